// File: rtl/uart_rx_cfg_if.sv
// Output side of the configurable UART receiver:
// held word plus error flags under a valid/ready handshake.
interface uart_rx_cfg_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_rx_ready;
   logic                 o_rx_valid;
   logic [DATA_BITS-1:0] o_rx_data;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_break;

   modport master (
      input  i_rx_ready,
      output o_rx_valid,
      output o_rx_data,
      output o_parity_err,
      output o_frame_err,
      output o_break
   );

   modport slave (
      output i_rx_ready,
      input  o_rx_valid,
      input  o_rx_data,
      input  o_parity_err,
      input  o_frame_err,
      input  o_break
   );
endinterface

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable width/parity/stops,
// per-frame error flags, held output word with overrun reporting.
module uart_rx_cfg #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_BITS    = 8,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_rx,
   uart_rx_cfg_if.master rx_if,
   output logic          o_overrun,
   output logic          o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
   localparam logic STOP_LAST = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
   } state_t;

   state_t st, nxt;
   logic rx_m, rx_s;
   logic [CW-1:0] cnt;
   logic [IW-1:0] bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic par_bit, ferr, stop_idx;
   logic mid, tick, done;
   logic perr_w, brk_w, xfer;
   logic valid_q, perr_q, ferr_q, brk_q;
   logic [DATA_BITS-1:0] data_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= i_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) st <= IDLE;
      else          st <= nxt;
   end

   always_comb begin
      nxt = IDLE;
      case (st)
         IDLE:      nxt = rx_s ? IDLE : START;
         START:     nxt = !mid ? START : (rx_s ? IDLE : DATA);
         DATA: begin
            nxt = DATA;
            if (tick && bit_idx == LAST)
               nxt = PARITY_EN ? PARITY : STOP;
         end
         PARITY:    nxt = tick ? STOP : PARITY;
         STOP: begin
            nxt = STOP;
            if (tick && stop_idx == STOP_LAST)
               nxt = DONE;
         end
         DONE:      nxt = ferr ? WAIT_HIGH : IDLE;
         WAIT_HIGH: nxt = rx_s ? IDLE : WAIT_HIGH;
         default:   nxt = IDLE;
      endcase
   end

   always_comb begin
      mid    = (st == START) && (cnt == HALF);
      tick   = (st == DATA || st == PARITY || st == STOP)
               && (cnt == FULL);
      done   = (st == DONE);
      o_busy = (st != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
         ferr     <= 1'b0;
         stop_idx <= 1'b0;
      end else begin
         if (st == IDLE || st == DONE || st == WAIT_HIGH || mid || tick)
            cnt <= '0;
         else
            cnt <= cnt + 1'b1;
         if (mid) begin
            bit_idx  <= '0;
            par_bit  <= 1'b0;
            ferr     <= 1'b0;
            stop_idx <= 1'b0;
         end
         if (tick) begin
            case (st)
               DATA: begin
                  shift   <= {rx_s, shift[DATA_BITS-1:1]};
                  bit_idx <= bit_idx + 1'b1;
               end
               PARITY: par_bit <= rx_s;
               STOP: begin
                  ferr     <= ferr | ~rx_s;
                  stop_idx <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // par_bit stays 0 without parity, so the break test needs no gating
   assign perr_w = PARITY_EN && ((^shift ^ par_bit) != PARITY_ODD);
   assign brk_w  = ferr && (shift == '0) && !par_bit;
   assign xfer   = valid_q && rx_if.i_rx_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         brk_q     <= 1'b0;
         o_overrun <= 1'b0;
      end else begin
         if (done && (!valid_q || xfer)) begin
            valid_q <= 1'b1;
            data_q  <= shift;
            perr_q  <= perr_w;
            ferr_q  <= ferr;
            brk_q   <= brk_w;
         end else if (xfer) begin
            valid_q <= 1'b0;
         end
         o_overrun <= done && valid_q && !rx_if.i_rx_ready;
      end
   end

   assign rx_if.o_rx_valid   = valid_q;
   assign rx_if.o_rx_data    = data_q;
   assign rx_if.o_parity_err = perr_q;
   assign rx_if.o_frame_err  = ferr_q;
   assign rx_if.o_break      = brk_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances
// driven by bit-level serial frames at 16 clocks per bit.
module tb_uart_rx_cfg;
   logic clk;
   logic rst_n;
   logic [2:0] rx;
   logic busy0, busy1, busy2;
   logic ovr_o0, ovr_o1, ovr_o2;

   int n_assert;
   int n_fail;
   int vcyc0;
   int ovr0;
   // entry = {brk, ferr, perr, data[8:0]}
   logic [11:0] log0[$];
   logic [11:0] log1[$];
   logic [11:0] log2[$];

   uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
   uart_rx_cfg_if #(.DATA_BITS(8)) if1 ();
   uart_rx_cfg_if #(.DATA_BITS(7)) if2 ();

   uart_rx_cfg #(
      .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b0),
      .PARITY_ODD(1'b0), .STOP_BITS(1)
   ) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[0]),
      .rx_if(if0), .o_overrun(ovr_o0), .o_busy(busy0)
   );

   uart_rx_cfg #(
      .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1'b1),
      .PARITY_ODD(1'b0), .STOP_BITS(1)
   ) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[1]),
      .rx_if(if1), .o_overrun(ovr_o1), .o_busy(busy1)
   );

   uart_rx_cfg #(
      .CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_EN(1'b1),
      .PARITY_ODD(1'b1), .STOP_BITS(2)
   ) u2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx[2]),
      .rx_if(if2), .o_overrun(ovr_o2), .o_busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (if0.o_rx_valid) vcyc0++;
      if (ovr_o0) ovr0++;
      if (if0.o_rx_valid && if0.i_rx_ready)
         log0.push_back({if0.o_break, if0.o_frame_err,
                         if0.o_parity_err, 1'b0, if0.o_rx_data});
      if (if1.o_rx_valid && if1.i_rx_ready)
         log1.push_back({if1.o_break, if1.o_frame_err,
                         if1.o_parity_err, 1'b0, if1.o_rx_data});
      if (if2.o_rx_valid && if2.i_rx_ready)
         log2.push_back({if2.o_break, if2.o_frame_err,
                         if2.o_parity_err, 2'b00, if2.o_rx_data});
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h",
                  tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int d, input logic v);
      rx[d] = v;
      cyc(16);
   endtask

   task automatic send(input int d, input logic [8:0] data,
                       input int nb, input bit pen, input logic pb,
                       input int nstop, input logic stopv);
      drive_bit(d, 1'b0);
      for (int i = 0; i < nb; i++) drive_bit(d, data[i]);
      if (pen) drive_bit(d, pb);
      for (int i = 0; i < nstop; i++) drive_bit(d, stopv);
      rx[d] = 1'b1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      rx       = 3'b111;
      if0.i_rx_ready = 1'b1;
      if1.i_rx_ready = 1'b1;
      if2.i_rx_ready = 1'b1;
      cyc(4);
      chk("rst_valid", if0.o_rx_valid, 0);
      chk("rst_data", if0.o_rx_data, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_ovr", ovr_o0, 0);
      rst_n = 1'b1;
      cyc(4);

      // clean 8N1 word
      send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t1_count", log0.size(), 1);
      chk("t1_word", log0[0], 'h0A5);
      chk("t1_vcyc", vcyc0, 1);
      chk("t1_busy", busy0, 0);

      // even / odd parity
      send(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
      cyc(4);
      chk("t2_perr_cnt", log1.size(), 1);
      chk("t2_perr", log1[0], 'h203);
      send(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t2_pok", log1[1], 'h003);
      send(2, 9'h041, 7, 1'b1, 1'b1, 2, 1'b1);
      cyc(4);
      chk("t2_odd_cnt", log2.size(), 1);
      chk("t2_odd", log2[0], 'h041);

      // stall and overrun
      if0.i_rx_ready = 1'b0;
      send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
      send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t3_hold_v", if0.o_rx_valid, 1);
      chk("t3_hold_d", if0.o_rx_data, 'h11);
      chk("t3_ovr", ovr0, 1);
      chk("t3_nolog", log0.size(), 1);
      if0.i_rx_ready = 1'b1;
      cyc(1);
      chk("t3_drop_v", if0.o_rx_valid, 0);
      cyc(40);
      chk("t3_cnt", log0.size(), 2);
      chk("t3_word", log0[1], 'h011);

      // framing error, then break
      send(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b0);
      cyc(16);
      chk("t4_fe_cnt", log0.size(), 3);
      chk("t4_fe", log0[2], 'h45A);
      rx[0] = 1'b0;
      cyc(20 * 16);
      chk("t4_brk_busy", busy0, 1);
      chk("t4_brk_cnt", log0.size(), 4);
      chk("t4_brk", log0[3], 'hC00);
      rx[0] = 1'b1;
      cyc(32);
      chk("t4_idle", busy0, 0);
      chk("t4_one", log0.size(), 4);

      // glitch rejection
      rx[0] = 1'b0;
      cyc(3);
      rx[0] = 1'b1;
      cyc(32);
      chk("t5_glitch", log0.size(), 4);
      chk("t5_gbusy", busy0, 0);

      // reset mid-frame with a word held
      if0.i_rx_ready = 1'b0;
      send(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t5_held", if0.o_rx_data, 'h7E);
      rx[0] = 1'b0;
      cyc(16);
      rx[0] = 1'b1;
      cyc(8);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_v", if0.o_rx_valid, 0);
      chk("t5_rst_d", if0.o_rx_data, 0);
      chk("t5_rst_b", busy0, 0);
      cyc(2);
      rst_n = 1'b1;
      if0.i_rx_ready = 1'b1;
      cyc(4);
      send(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t5_cnt", log0.size(), 5);
      chk("t5_word", log0[4], 'h0C3);

      // back-to-back frames
      send(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1);
      send(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
      send(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1);
      cyc(4);
      chk("t6_cnt", log0.size(), 8);
      chk("t6_w0", log0[5], 'h000);
      chk("t6_w1", log0[6], 'h0FF);
      chk("t6_w2", log0[7], 'h055);
      chk("t6_ovr", ovr0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
